// File: rtl/sd_sector_read_arbiter.sv
// Round-robin arbiter sharing one SDReader sector-read port between NREQ requesters.
// Optional byte-count check on each sector enabled by defining SDARB_BYTECHK_EN.
module sd_sector_read_arbiter #(
  parameter int NREQ = 4,
  parameter int SECW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 card_ready,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SECW-1:0] req_sector,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      ack,
  output logic                 ack_err,
  output logic [NREQ-1:0]      dout_valid,
  output logic [8:0]           dout_addr,
  output logic [7:0]           dout_byte,
  output logic                 rd_start,
  output logic [SECW-1:0]      rd_sector,
  input  logic                 rd_done,
  input  logic                 rd_outreq,
  input  logic [8:0]           rd_outaddr,
  input  logic [7:0]           rd_outbyte
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   rr_ptr, rr_ptr_n;
  logic [NREQ-1:0] grant_n, ack_n;
  logic            rd_start_n;
  logic [SECW-1:0] rd_sector_n;

  logic            any_req, hi_found;
  logic [PW-1:0]   hi_idx, lo_idx, win_idx;
  logic [NREQ-1:0] win_onehot;
  logic [SECW-1:0] win_sector;
  logic            take_grant;

  // Winner is the lowest set index above rr_ptr, else the lowest set index overall (wrap).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    any_req  = 1'b0;
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (PW'(i) > rr_ptr)) begin
        hi_found = 1'b1;
        hi_idx   = PW'(i);
      end
      if (req[i]) begin
        any_req = 1'b1;
        lo_idx  = PW'(i);
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    win_onehot = '0;
    win_sector = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == win_idx) begin
        win_onehot[i] = 1'b1;
        win_sector    = req_sector[i*SECW +: SECW];
      end
    end
  end

  assign take_grant = (state == S_IDLE) && card_ready && any_req;

  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    grant_n     = grant;
    ack_n       = '0;
    rd_start_n  = rd_start;
    rd_sector_n = rd_sector;
    case (state)
      S_IDLE: begin
        if (take_grant) begin
          state_n     = S_BUSY;
          grant_n     = win_onehot;
          rd_sector_n = win_sector;
          rd_start_n  = 1'b1;
          rr_ptr_n    = win_idx;
        end
      end
      S_BUSY: begin
        if (rd_done) begin
          state_n    = S_ACK;
          rd_start_n = 1'b0;
          ack_n      = grant;
        end
      end
      S_ACK: begin
        state_n = S_IDLE;
        grant_n = '0;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= PW'(NREQ - 1);
      grant     <= '0;
      ack       <= '0;
      rd_start  <= 1'b0;
      rd_sector <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      grant     <= grant_n;
      ack       <= ack_n;
      rd_start  <= rd_start_n;
      rd_sector <= rd_sector_n;
    end
  end

  // Byte stream goes only to the current owner; address/data pass straight through.
  assign dout_valid = (state == S_BUSY && rd_outreq) ? grant : '0;
  assign dout_addr  = rd_outaddr;
  assign dout_byte  = rd_outbyte;

`ifdef SDARB_BYTECHK_EN
  logic [9:0] byte_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      ack_err  <= 1'b0;
    end else begin
      if (take_grant)
        byte_cnt <= '0;
      else if (state == S_BUSY && rd_outreq && byte_cnt != 10'h3FF)
        byte_cnt <= byte_cnt + 10'd1;
      ack_err <= (state == S_BUSY && rd_done) ? (byte_cnt != 10'd512) : 1'b0;
    end
  end
`else
  assign ack_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_sector_read_arbiter.sv
// Directed self-checking bench for sd_sector_read_arbiter (NREQ=4, SECW=32).
module tb_sd_sector_read_arbiter;
  localparam int NREQ = 4;
  localparam int SECW = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 card_ready;
  logic [NREQ-1:0]      req;
  logic [NREQ*SECW-1:0] req_sector;
  logic [NREQ-1:0]      grant, ack, dout_valid;
  logic                 ack_err;
  logic [8:0]           dout_addr;
  logic [7:0]           dout_byte;
  logic                 rd_start;
  logic [SECW-1:0]      rd_sector;
  logic                 rd_done, rd_outreq;
  logic [8:0]           rd_outaddr;
  logic [7:0]           rd_outbyte;

  int n_tests = 0;
  int n_fail  = 0;

  sd_sector_read_arbiter #(.NREQ(NREQ), .SECW(SECW)) dut (
    .clk(clk), .rst(rst), .card_ready(card_ready), .req(req), .req_sector(req_sector),
    .grant(grant), .ack(ack), .ack_err(ack_err), .dout_valid(dout_valid),
    .dout_addr(dout_addr), .dout_byte(dout_byte), .rd_start(rd_start),
    .rd_sector(rd_sector), .rd_done(rd_done), .rd_outreq(rd_outreq),
    .rd_outaddr(rd_outaddr), .rd_outbyte(rd_outbyte)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err(input int nbytes);
`ifdef SDARB_BYTECHK_EN
    return nbytes != 512;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sector(input int i, input logic [SECW-1:0] s);
    req_sector[i*SECW +: SECW] = s;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    card_ready = 1'b1;
    req        = '0;
    req_sector = '0;
    rd_done    = 1'b0;
    rd_outreq  = 1'b0;
    rd_outaddr = '0;
    rd_outbyte = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Streams nbytes to the current owner, finishes with rd_done and checks the ack handshake.
  task automatic serve(input int nbytes, input logic [NREQ-1:0] owner,
                       input logic [NREQ-1:0] req_after, input string tag);
    int own = 0;
    int other = 0;
    for (int b = 0; b < nbytes; b++) begin
      rd_outreq  = 1'b1;
      rd_outaddr = 9'(b);
      rd_outbyte = 8'(b * 7);
      #1;
      if (dout_valid == owner) own++;
      if ((dout_valid & ~owner) != '0) other++;
      if (b == 3) begin
        check({tag, ".dout_addr"}, 64'(dout_addr), 64'(9'd3));
        check({tag, ".dout_byte"}, 64'(dout_byte), 64'(8'd21));
      end
      tick();
    end
    rd_outreq = 1'b0;
    rd_done   = 1'b1;
    tick();
    rd_done = 1'b0;
    req     = req_after;
    check({tag, ".ack"},      64'(ack),      64'(owner));
    check({tag, ".ack_err"},  64'(ack_err),  64'(exp_err(nbytes)));
    check({tag, ".rd_start"}, 64'(rd_start), 64'(1'b0));
    check({tag, ".grant_ack"},64'(grant),    64'(owner));
    check({tag, ".own_bytes"},64'(own),      64'(nbytes));
    check({tag, ".other_dv"}, 64'(other),    64'd0);
    tick();
    check({tag, ".ack_pulse"},64'(ack),      64'd0);
    check({tag, ".grant_rel"},64'(grant),    64'd0);
  endtask

  initial begin
    int bad;
    logic [NREQ-1:0] rr_seq [6];
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    // Reset values and single requester, full 512-byte sector
    do_reset();
    check("rst.grant",    64'(grant),    64'd0);
    check("rst.ack",      64'(ack),      64'd0);
    check("rst.ack_err",  64'(ack_err),  64'd0);
    check("rst.rd_start", 64'(rd_start), 64'd0);
    check("rst.rd_sector",64'(rd_sector),64'd0);
    set_sector(0, 32'd5);
    req = 4'b0001;
    tick();
    check("t1.grant",     64'(grant),    64'(4'b0001));
    check("t1.rd_start",  64'(rd_start), 64'd1);
    check("t1.rd_sector", 64'(rd_sector),64'd5);
    set_sector(0, 32'd99);
    tick();
    check("t1.sector_hold", 64'(rd_sector), 64'd5);
    check("t1.start_hold",  64'(rd_start),  64'd1);
    serve(512, 4'b0001, 4'b0000, "t1");

    // rd_done / rd_outreq in IDLE are ignored
    rd_done   = 1'b1;
    rd_outreq = 1'b1;
    #1;
    check("idle.dout_valid", 64'(dout_valid), 64'd0);
    tick();
    rd_done   = 1'b0;
    rd_outreq = 1'b0;
    check("idle.ack",   64'(ack),   64'd0);
    check("idle.grant", 64'(grant), 64'd0);

    // Two simultaneous requests: 0 then 2, next grant exactly two cycles after ack
    do_reset();
    set_sector(0, 32'd10);
    set_sector(2, 32'd22);
    req = 4'b0101;
    tick();
    check("t2.grant0", 64'(grant),     64'(4'b0001));
    check("t2.sector0",64'(rd_sector), 64'd10);
    serve(16, 4'b0001, 4'b0100, "t2a");
    tick();
    check("t2.grant2", 64'(grant),     64'(4'b0100));
    check("t2.sector2",64'(rd_sector), 64'd22);
    serve(16, 4'b0100, 4'b0000, "t2b");

    // All four held: strict rotation 0,1,2,3,0,1
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t3.rr%0d", k), 64'(grant), 64'(rr_seq[k]));
      serve(4, rr_seq[k], 4'b1111, $sformatf("t3.%0d", k));
    end
    req = '0;
    tick();

    // card_ready low blocks granting
    do_reset();
    card_ready = 1'b0;
    req = 4'b0010;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (grant != '0 || rd_start != 1'b0) bad++;
    end
    check("t4.blocked", 64'(bad), 64'd0);
    card_ready = 1'b1;
    tick();
    check("t4.grant", 64'(grant), 64'(4'b0010));
    serve(4, 4'b0010, 4'b0000, "t4");

    // Reset mid-BUSY after 200 bytes, then a clean 511-byte sector for req2
    do_reset();
    set_sector(2, 32'd77);
    req = 4'b0100;
    tick();
    check("t5.grant", 64'(grant), 64'(4'b0100));
    for (int b = 0; b < 200; b++) begin
      rd_outreq  = 1'b1;
      rd_outaddr = 9'(b);
      tick();
    end
    rst = 1'b1;
    #1;
    check("t5.rst_grant",    64'(grant),      64'd0);
    check("t5.rst_rd_start", 64'(rd_start),   64'd0);
    check("t5.rst_ack",      64'(ack),        64'd0);
    check("t5.rst_sector",   64'(rd_sector),  64'd0);
    check("t5.rst_dv",       64'(dout_valid), 64'd0);
    tick();
    rd_outreq = 1'b0;
    rst = 1'b0;
    tick();
    check("t5.regrant", 64'(grant),     64'(4'b0100));
    check("t5.no_ack",  64'(ack),       64'd0);
    check("t5.sector",  64'(rd_sector), 64'd77);
    serve(511, 4'b0100, 4'b0000, "t5");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
